// File: rtl/pipeline_branch_resolve_if.sv
// MEM-stage branch resolution bundle: resolution inputs from the pipe,
// IF-stage BHT lookup, redirect/flush controls and statistics outputs.
interface pipeline_branch_resolve_if #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned CNT_WIDTH = 16
);
   logic                 valid_in_Mem;
   logic [2:0]           BrType_in_Mem;
   logic                 zero_in_Mem;
   logic                 lt_in_Mem;
   logic                 ltu_in_Mem;
   logic                 Predicted_in_Mem;
   logic [XLEN-1:0]      PC_in_Mem;
   logic [XLEN-1:0]      target_in_Mem;
   logic [XLEN-1:0]      PC_in_IF;
   logic                 predict_taken_IF;
   logic                 PCSrc;
   logic [XLEN-1:0]      redirect_PC;
   logic                 flush;
   logic [CNT_WIDTH-1:0] branch_cnt;
   logic [CNT_WIDTH-1:0] mispredict_cnt;

   // Pipeline side: drives the MEM/IF information, consumes redirect controls.
   modport master (
      output valid_in_Mem, BrType_in_Mem, zero_in_Mem, lt_in_Mem, ltu_in_Mem,
             Predicted_in_Mem, PC_in_Mem, target_in_Mem, PC_in_IF,
      input  predict_taken_IF, PCSrc, redirect_PC, flush, branch_cnt, mispredict_cnt
   );

   // Resolver side.
   modport slave (
      input  valid_in_Mem, BrType_in_Mem, zero_in_Mem, lt_in_Mem, ltu_in_Mem,
             Predicted_in_Mem, PC_in_Mem, target_in_Mem, PC_in_IF,
      output predict_taken_IF, PCSrc, redirect_PC, flush, branch_cnt, mispredict_cnt
   );
endinterface

// File: rtl/pipeline_branch_resolve.sv
// MEM-stage branch resolver: RV32 branch/jump resolution, 2-bit BHT for
// IF-stage prediction, registered redirect pulse, multi-cycle flush and
// saturating branch/mispredict statistics.
module pipeline_branch_resolve #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned BHT_IDX_BITS = 4,
   parameter int unsigned FLUSH_CYCLES = 3,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   pipeline_branch_resolve_if.slave bus
);
   localparam int unsigned BHT_ENTRIES = 1 << BHT_IDX_BITS;

   typedef enum logic {
      IDLE,
      FLUSHING
   } state_e;

   state_e                  state_q, state_d;
   logic [3:0]              flush_cnt_q, flush_cnt_d;
   logic                    pcsrc_q, pcsrc_d;
   logic [XLEN-1:0]         redirect_pc_q, redirect_pc_d;
   logic [CNT_WIDTH-1:0]    branch_cnt_q, branch_cnt_d;
   logic [CNT_WIDTH-1:0]    mispredict_cnt_q, mispredict_cnt_d;
   logic [1:0]              bht_q [BHT_ENTRIES];
   logic [1:0]              bht_cur;
   logic [1:0]              bht_entry_d;
   logic                    bht_we;
   logic [BHT_IDX_BITS-1:0] mem_idx;
   logic [BHT_IDX_BITS-1:0] if_idx;
   logic                    active;
   logic                    is_branch;
   logic                    is_cond;
   logic                    taken;
   logic                    mispredict;
   logic                    unused_pc_if_bits;

   assign mem_idx           = bus.PC_in_Mem[BHT_IDX_BITS+1:2];
   assign if_idx            = bus.PC_in_IF[BHT_IDX_BITS+1:2];
   assign unused_pc_if_bits = ^{bus.PC_in_IF[XLEN-1:BHT_IDX_BITS+2], bus.PC_in_IF[1:0]};

   // Wrong-path instructions arriving during a flush are ignored entirely.
   assign active     = bus.valid_in_Mem && (state_q == IDLE);
   assign is_branch  = (bus.BrType_in_Mem != 3'b000);
   assign is_cond    = is_branch && (bus.BrType_in_Mem != 3'b111);
   assign mispredict = active && is_branch && (taken != bus.Predicted_in_Mem);

   // Branch condition evaluation from the EX comparison flags.
   always_comb begin
      taken = 1'b0;
      case (bus.BrType_in_Mem)
         3'b001:  taken = bus.zero_in_Mem;
         3'b010:  taken = ~bus.zero_in_Mem;
         3'b011:  taken = bus.lt_in_Mem;
         3'b100:  taken = ~bus.lt_in_Mem;
         3'b101:  taken = bus.ltu_in_Mem;
         3'b110:  taken = ~bus.ltu_in_Mem;
         3'b111:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   // Saturating 2-bit counter update for the resolved entry.
   always_comb begin
      bht_we      = active && is_cond;
      bht_cur     = bht_q[mem_idx];
      bht_entry_d = bht_cur;
      if (taken) begin
         if (bht_cur != 2'b11) bht_entry_d = bht_cur + 2'd1;
      end else begin
         if (bht_cur != 2'b00) bht_entry_d = bht_cur - 2'd1;
      end
   end

   // Redirect pulse, redirect target and saturating statistics next-state.
   always_comb begin
      pcsrc_d          = mispredict;
      redirect_pc_d    = redirect_pc_q;
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (mispredict) begin
         redirect_pc_d = taken ? bus.target_in_Mem : (bus.PC_in_Mem + XLEN'(4));
      end
      if (active && is_branch && (branch_cnt_q != '1)) begin
         branch_cnt_d = branch_cnt_q + 1'b1;
      end
      if (mispredict && (mispredict_cnt_q != '1)) begin
         mispredict_cnt_d = mispredict_cnt_q + 1'b1;
      end
   end

   // Flush FSM next-state: counter leaves FLUSHING on the edge it would hit 0.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         IDLE: begin
            if (mispredict) begin
               state_d     = FLUSHING;
               flush_cnt_d = 4'(FLUSH_CYCLES);
            end
         end
         FLUSHING: begin
            flush_cnt_d = flush_cnt_q - 4'd1;
            if (flush_cnt_q == 4'd1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, redirect, statistics and BHT registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         flush_cnt_q      <= '0;
         pcsrc_q          <= 1'b0;
         redirect_pc_q    <= '0;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
         for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else begin
         state_q          <= state_d;
         flush_cnt_q      <= flush_cnt_d;
         pcsrc_q          <= pcsrc_d;
         redirect_pc_q    <= redirect_pc_d;
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
         if (bht_we) bht_q[mem_idx] <= bht_entry_d;
      end
   end

   assign bus.predict_taken_IF = bht_q[if_idx][1];
   assign bus.PCSrc            = pcsrc_q;
   assign bus.redirect_PC      = redirect_pc_q;
   assign bus.flush            = (state_q == FLUSHING);
   assign bus.branch_cnt       = branch_cnt_q;
   assign bus.mispredict_cnt   = mispredict_cnt_q;
endmodule

// File: tb/tb_pipeline_branch_resolve.sv
// Bench for pipeline_branch_resolve: directed vectors, expected redirect
// targets queued at issue and checked by a PCSrc-driven monitor. A second
// instance with 2-bit counters sees the same stream to exercise saturation.
module tb_pipeline_branch_resolve;
   logic clk;
   logic rst;
   int   n_vec = 0;
   int   n_mis = 0;
   logic [31:0] exp_q [$];

   pipeline_branch_resolve_if #(.XLEN(32), .CNT_WIDTH(16)) bif ();
   pipeline_branch_resolve_if #(.XLEN(32), .CNT_WIDTH(2))  bsat ();

   pipeline_branch_resolve #(
      .XLEN(32), .BHT_IDX_BITS(4), .FLUSH_CYCLES(3), .CNT_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .bus(bif.slave)
   );

   pipeline_branch_resolve #(
      .XLEN(32), .BHT_IDX_BITS(4), .FLUSH_CYCLES(3), .CNT_WIDTH(2)
   ) dut_sat (
      .clk(clk), .rst(rst), .bus(bsat.slave)
   );

   assign bsat.valid_in_Mem     = bif.valid_in_Mem;
   assign bsat.BrType_in_Mem    = bif.BrType_in_Mem;
   assign bsat.zero_in_Mem      = bif.zero_in_Mem;
   assign bsat.lt_in_Mem        = bif.lt_in_Mem;
   assign bsat.ltu_in_Mem       = bif.ltu_in_Mem;
   assign bsat.Predicted_in_Mem = bif.Predicted_in_Mem;
   assign bsat.PC_in_Mem        = bif.PC_in_Mem;
   assign bsat.target_in_Mem    = bif.target_in_Mem;
   assign bsat.PC_in_IF         = bif.PC_in_IF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every redirect pulse must match the oldest queued target.
   always @(negedge clk) begin
      if (bif.PCSrc === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_pcsrc: got PCSrc=1 redirect 0x%0h expected no redirect at %0t",
                     bif.redirect_PC, $time);
         end else begin
            chk("redirect_PC", bif.redirect_PC, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic v, input logic [2:0] bt, input logic z, input logic l,
                         input logic lu, input logic p, input logic [31:0] pc,
                         input logic [31:0] tgt);
      bif.valid_in_Mem     = v;
      bif.BrType_in_Mem    = bt;
      bif.zero_in_Mem      = z;
      bif.lt_in_Mem        = l;
      bif.ltu_in_Mem       = lu;
      bif.Predicted_in_Mem = p;
      bif.PC_in_Mem        = pc;
      bif.target_in_Mem    = tgt;
   endtask

   task automatic idle(input int n);
      bif.valid_in_Mem = 1'b0;
      repeat (n) step();
   endtask

   task automatic chk_pred(input string name, input logic [31:0] pc, input logic e);
      bif.PC_in_IF = pc;
      @(negedge clk);
      chk(name, 32'(bif.predict_taken_IF), 32'(e));
      step();
   endtask

   // Entered at cycle N+1 of a mispredict; optionally drives wrong-path
   // bne mispredicts (same BHT index as 0x100) that must be ignored.
   task automatic flush_window(input bit wrong_path);
      for (int c = 1; c <= 3; c++) begin
         chk("flush_high", 32'(bif.flush), 32'd1);
         chk("pcsrc_pulse", 32'(bif.PCSrc), (c == 1) ? 32'd1 : 32'd0);
         if (wrong_path) set_in(1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h300);
         else            bif.valid_in_Mem = 1'b0;
         step();
      end
      bif.valid_in_Mem = 1'b0;
      chk("flush_low", 32'(bif.flush), 32'd0);
      chk("pcsrc_low", 32'(bif.PCSrc), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      set_in(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      bif.PC_in_IF = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      chk("rst_pcsrc", 32'(bif.PCSrc), 32'd0);
      chk("rst_flush", 32'(bif.flush), 32'd0);
      chk("rst_redirect", bif.redirect_PC, 32'h0);
      chk("rst_branch_cnt", 32'(bif.branch_cnt), 32'd0);
      chk("rst_mispredict_cnt", 32'(bif.mispredict_cnt), 32'd0);
      for (int i = 0; i < 16; i++) chk_pred("rst_predict", 32'(i) << 2, 1'b0);

      // beq taken, predicted not-taken: redirect to 0x80; wrong-path ignored
      exp_q.push_back(32'h80);
      set_in(1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h80);
      step();
      flush_window(1'b1);
      chk("beq_branch_cnt", 32'(bif.branch_cnt), 32'd1);
      chk("beq_mispredict_cnt", 32'(bif.mispredict_cnt), 32'd1);
      chk_pred("beq_bht_trained", 32'h100, 1'b1);

      // bgeu not-taken at top of address space: PC+4 wraps to 0, entry15 -> 00
      exp_q.push_back(32'h0);
      set_in(1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h40);
      step();
      flush_window(1'b0);
      chk_pred("bgeu_bht_dec", 32'hFFFF_FFFC, 1'b0);
      // one taken beq on entry15: 00 -> 01 still predicts not-taken
      exp_q.push_back(32'h200);
      set_in(1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3C, 32'h200);
      step();
      flush_window(1'b0);
      chk_pred("entry15_was_00", 32'h3C, 1'b0);
      chk("cnt_after_bgeu_b", 32'(bif.branch_cnt), 32'd3);
      chk("cnt_after_bgeu_m", 32'(bif.mispredict_cnt), 32'd3);

      // jump predicted taken, 3 taken beq predicted taken, 1 not-taken beq, 1 none
      set_in(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20, 32'h400);
      step();
      chk("jump_no_pcsrc", 32'(bif.PCSrc), 32'd0);
      chk("jump_no_flush", 32'(bif.flush), 32'd0);
      set_in(1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h500);
      repeat (3) step();
      set_in(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h500);
      step();
      set_in(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h500);
      step();
      idle(1);
      chk_pred("jump_no_train", 32'h20, 1'b0);
      chk_pred("bht_sat_11", 32'h10, 1'b1);
      chk("seq_branch_cnt", 32'(bif.branch_cnt), 32'd8);
      chk("seq_mispredict_cnt", 32'(bif.mispredict_cnt), 32'd3);
      chk("sat_branch_cnt", 32'(bsat.branch_cnt), 32'd3);
      chk("sat_mispredict_cnt", 32'(bsat.mispredict_cnt), 32'd3);

      // bltu mispredict, reset in 2nd flush cycle
      exp_q.push_back(32'h1000);
      set_in(1'b1, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 32'h1000);
      step();
      bif.valid_in_Mem = 1'b0;
      chk("mid_flush_1", 32'(bif.flush), 32'd1);
      step();
      chk("mid_flush_2", 32'(bif.flush), 32'd1);
      rst = 1'b1;
      step();
      chk("rst_abort_flush", 32'(bif.flush), 32'd0);
      chk("rst_abort_pcsrc", 32'(bif.PCSrc), 32'd0);
      chk("rst_abort_redirect", bif.redirect_PC, 32'h0);
      chk("rst_abort_branch_cnt", 32'(bif.branch_cnt), 32'd0);
      chk("rst_abort_mispredict_cnt", 32'(bif.mispredict_cnt), 32'd0);
      chk("rst_abort_sat_cnt", 32'(bsat.mispredict_cnt), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) chk_pred("rst_abort_predict", 32'(i) << 2, 1'b0);

      // Four mispredicts: 2-bit counters saturate at 3, 16-bit reach 4
      for (int k = 1; k <= 4; k++) begin
         exp_q.push_back(32'h100);
         set_in(1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'h80, 32'h100);
         step();
         flush_window(1'b0);
         if (k >= 3) chk("sat_mispredict_hold", 32'(bsat.mispredict_cnt), 32'd3);
      end
      chk("sat_branch_hold", 32'(bsat.branch_cnt), 32'd3);
      chk("final_mispredict_cnt", 32'(bif.mispredict_cnt), 32'd4);
      chk("final_branch_cnt", 32'(bif.branch_cnt), 32'd4);

      idle(2);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
